id_ex_pipe: RTL

- ID/EX pipeline register with load-use hazard detection and branch flush for the pipelined RISC-V core.
- Sits directly upstream of the EX-stage forwarding logic and ALU.
- Captures decoded operands and control from ID, and supplies rs1_ex/rs2_ex/rd_ex and operand data to EX.
- Inserts a one-cycle bubble and stalls IF/ID on a load-use hazard. Tracks stall cycles in a saturating counter.

---
 rtl/id_ex_pipe.sv | 114 +++++++++++
 1 files changed

// File: rtl/id_ex_pipe.sv
// Purpose : ID/EX pipeline register with load-use hazard detection, bubble insertion and branch flush.
// Latency : one cycle ID->EX; a load-use hazard inserts exactly one bubble.
// Backpr. : stall_id (combinational) holds PC and IF/ID for the hazard cycle; enable=0 freezes everything.
//
// Ports:
//   clk, arst_n        core clock (rising edge), asynchronous active-low reset
//   enable             global pipeline enable
//   *_id               decoded instruction fields from ID, flush from branch resolution
//   *_ex               registered EX-stage copies
//   stall_id           hold request towards PC / IF/ID
//   stall_cnt          saturating count of load-use bubbles inserted
module id_ex_pipe #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              enable,
  input  logic              valid_id,
  input  logic [4:0]        rs1_id,
  input  logic [4:0]        rs2_id,
  input  logic [4:0]        rd_id,
  input  logic              uses_rs1_id,
  input  logic              uses_rs2_id,
  input  logic [DATA_W-1:0] rdata1_id,
  input  logic [DATA_W-1:0] rdata2_id,
  input  logic [DATA_W-1:0] imm_id,
  input  logic [DATA_W-1:0] pc_id,
  input  logic [CTRL_W-1:0] ctrl_id,
  input  logic              reg_write_id,
  input  logic              mem_read_id,
  input  logic              mem_write_id,
  input  logic              flush,
  output logic              valid_ex,
  output logic [4:0]        rs1_ex,
  output logic [4:0]        rs2_ex,
  output logic [4:0]        rd_ex,
  output logic [DATA_W-1:0] rdata1_ex,
  output logic [DATA_W-1:0] rdata2_ex,
  output logic [DATA_W-1:0] imm_ex,
  output logic [DATA_W-1:0] pc_ex,
  output logic [CTRL_W-1:0] ctrl_ex,
  output logic              reg_write_ex,
  output logic              mem_read_ex,
  output logic              mem_write_ex,
  output logic              stall_id,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic hazard;

  // A load in EX whose destination is read by the ID instruction cannot be
  // forwarded in time; x0 never creates a dependency.
  assign hazard = valid_id & valid_ex & mem_read_ex & (rd_ex != 5'd0) &
                  ((uses_rs1_id & (rs1_id == rd_ex)) |
                   (uses_rs2_id & (rs2_id == rd_ex)));

  // A taken branch squashes the ID instruction, so there is nothing to hold.
  // valid_ex is cleared by reset, which keeps this low while in reset.
  assign stall_id = hazard & ~flush & enable;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      valid_ex     <= 1'b0;
      rs1_ex       <= '0;
      rs2_ex       <= '0;
      rd_ex        <= '0;
      rdata1_ex    <= '0;
      rdata2_ex    <= '0;
      imm_ex       <= '0;
      pc_ex        <= '0;
      ctrl_ex      <= '0;
      reg_write_ex <= 1'b0;
      mem_read_ex  <= 1'b0;
      mem_write_ex <= 1'b0;
      stall_cnt    <= '0;
    end else if (enable) begin
      if (flush || hazard) begin
        // Bubble: indices cleared too so forwarding never matches a dead slot.
        valid_ex     <= 1'b0;
        rs1_ex       <= '0;
        rs2_ex       <= '0;
        rd_ex        <= '0;
        rdata1_ex    <= '0;
        rdata2_ex    <= '0;
        imm_ex       <= '0;
        pc_ex        <= '0;
        ctrl_ex      <= '0;
        reg_write_ex <= 1'b0;
        mem_read_ex  <= 1'b0;
        mem_write_ex <= 1'b0;
        // Only genuine load-use stalls are counted; flush has priority.
        if (!flush && (stall_cnt != {CNT_W{1'b1}}))
          stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        valid_ex     <= valid_id;
        rs1_ex       <= rs1_id;
        rs2_ex       <= rs2_id;
        rd_ex        <= rd_id;
        rdata1_ex    <= rdata1_id;
        rdata2_ex    <= rdata2_id;
        imm_ex       <= imm_id;
        pc_ex        <= pc_id;
        ctrl_ex      <= ctrl_id;
        // Forwarding downstream relies on reg_write_ex never targeting x0.
        reg_write_ex <= reg_write_id & valid_id & (rd_id != 5'd0);
        mem_read_ex  <= mem_read_id & valid_id;
        mem_write_ex <= mem_write_id & valid_id;
      end
    end
  end

endmodule
